// File: rtl/sdio_pkg.sv
// Shared definitions for the SD host command and data line engines.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package sdio_pkg;

  // Response type field as written by the control block
  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,  // no response expected
    RESP_R1   = 2'b01,  // short, CRC and index checked (R1/R6/R7)
    RESP_R2   = 2'b10,  // long 136-bit, CRC over the CID/CSD body
    RESP_R3   = 2'b11   // short, no CRC or index check
  } resp_type_e;

  // CRC7 generator x^7 + x^3 + 1, leading term implied
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // Frame lengths on the CMD line, start and end bits included
  localparam int CMD_FRAME_LEN  = 48;
  localparam int LONG_FRAME_LEN = 136;

  // Command engine states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TX        = 3'd1,
    ST_WAIT_RESP = 3'd2,
    ST_RX        = 3'd3,
    ST_NCC       = 3'd4,
    ST_DONE      = 3'd5
  } cmd_state_e;

endpackage

// File: rtl/sdio_crc7.sv
// Serial CRC7 (x^7+x^3+1) accumulator, one data bit per enabled cycle.
// Latency: crc reflects a bit the cycle after it is presented with en.
// Backpressure: none; clr wins over en, value holds while en is low.
module sdio_crc7
  import sdio_pkg::*;
(
  input  logic       sd_clk,
  input  logic       sd_rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;

  assign fb = din ^ crc[6];

  // LFSR update: shift left, fold the polynomial in when feedback is set
  always_ff @(posedge sd_clk) begin
    if (sd_rst || clr) begin
      crc <= 7'h00;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sdio_cmd.sv
// SD CMD line engine: sends a 48-bit command, receives/checks the response, enforces Ncc.
// Latency: one bit per tx_en/rx_en strobe; cmd_done one cycle after the last Ncc strobe.
// Backpressure: cmd_start ignored while busy; with no strobes every state simply holds.
module sdio_cmd
  import sdio_pkg::*;
#(
  parameter int RESP_TIMEOUT = 64,
  parameter int NCC          = 8
) (
  input  logic         sd_clk,
  input  logic         sd_rst,
  input  logic         tx_en,
  input  logic         rx_en,
  input  logic         cmd_start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  input  logic         cmd_i,
  output logic         cmd_o,
  output logic         cmd_oe,
  output logic         cmd_busy,
  output logic         cmd_done,
  output logic [119:0] resp,
  output logic         resp_timeout,
  output logic         resp_crc_err,
  output logic         resp_idx_err
);

  localparam int TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam int NW = (NCC > 1) ? $clog2(NCC) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(RESP_TIMEOUT - 1);
  localparam logic [NW-1:0] NCC_LAST = NW'(NCC - 1);

  // TX bit counter milestones: 40 header/arg bits, 7 CRC bits, end bit, then release
  localparam logic [5:0] TX_CRC_START = 6'd40;
  localparam logic [5:0] TX_END_BIT   = 6'd47;
  localparam logic [5:0] TX_RELEASE   = 6'(CMD_FRAME_LEN);

  // RX bit counter: index of the final (end) bit of each frame type
  localparam logic [7:0] SHORT_LAST = 8'(CMD_FRAME_LEN - 1);
  localparam logic [7:0] LONG_LAST  = 8'(LONG_FRAME_LEN - 1);

  cmd_state_e state, state_nxt;

  logic [5:0]   idx_q;
  resp_type_e   rtype_q;
  logic [39:0]  tx_shift;
  logic [5:0]   tx_cnt;
  logic [7:0]   rx_cnt;
  logic [126:0] rx_shift;
  logic [TW-1:0] wait_cnt;
  logic [NW-1:0] ncc_cnt;

  logic         crc_clr, crc_en, crc_din;
  logic [6:0]   crc_val;
  logic         rx_finish;
  logic         tx_bit;
  logic [2:0]   crc_sel;

  logic         rx_long;
  logic [7:0]   rx_last;
  logic [127:0] rx_frame;
  logic         crc_bad, end_bad, tbit_bad, idx_bad;

  // One CRC engine is shared: TX and RX never overlap in time
  sdio_crc7 u_crc7 (
    .sd_clk (sd_clk),
    .sd_rst (sd_rst),
    .clr    (crc_clr),
    .en     (crc_en),
    .din    (crc_din),
    .crc    (crc_val)
  );

  assign rx_long  = (rtype_q == RESP_R2);
  assign rx_last  = rx_long ? LONG_LAST : SHORT_LAST;
  // Frame as it stands once the bit on cmd_i is taken; bit 0 is the newest
  assign rx_frame = {rx_shift, cmd_i};
  assign crc_bad  = (rx_frame[7:1] != crc_val);
  assign end_bad  = ~rx_frame[0];
  assign tbit_bad = ~rx_long & rx_frame[46];
  assign idx_bad  = (rx_frame[45:40] != idx_q);

  // State register
  always_ff @(posedge sd_clk) begin
    if (sd_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, CRC steering and status outputs
  always_comb begin
    state_nxt = state;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    crc_din   = 1'b0;
    rx_finish = 1'b0;
    cmd_busy  = 1'b0;
    cmd_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_start) begin
          state_nxt = ST_TX;
          crc_clr   = 1'b1;
        end
      end
      ST_TX: begin
        cmd_busy = 1'b1;
        if (tx_en) begin
          if (tx_cnt == TX_RELEASE) begin
            state_nxt = (rtype_q == RESP_NONE) ? ST_NCC : ST_WAIT_RESP;
          end else if (tx_cnt < TX_CRC_START) begin
            crc_en  = 1'b1;
            crc_din = tx_shift[39];
          end
        end
      end
      ST_WAIT_RESP: begin
        cmd_busy = 1'b1;
        if (rx_en) begin
          if (!cmd_i) begin
            // Start bit: it is a zero, so a cleared CRC already accounts for it
            state_nxt = ST_RX;
            crc_clr   = 1'b1;
          end else if (wait_cnt == TO_LAST) begin
            state_nxt = ST_NCC;
          end
        end
      end
      ST_RX: begin
        cmd_busy = 1'b1;
        if (rx_en) begin
          crc_din = cmd_i;
          // Long frames skip the 8-bit header; short frames cover bits 47..8
          crc_en  = rx_long ? ((rx_cnt >= 8'd8) && (rx_cnt < 8'd128)) : (rx_cnt < 8'd40);
          if (rx_cnt == rx_last) begin
            rx_finish = 1'b1;
            state_nxt = ST_NCC;
          end
        end
      end
      ST_NCC: begin
        cmd_busy = 1'b1;
        if (tx_en && (ncc_cnt == NCC_LAST)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        cmd_done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outgoing bit for the current TX slot: header/arg, then CRC MSB first, then end bit
  always_comb begin
    crc_sel = 3'(6'd46 - tx_cnt);
    tx_bit  = 1'b1;
    if (tx_cnt < TX_CRC_START) begin
      tx_bit = tx_shift[39];
    end else if (tx_cnt < TX_END_BIT) begin
      tx_bit = crc_val[crc_sel];
    end
  end

  // Operand capture, pad drive, bit counters, response and status registers
  always_ff @(posedge sd_clk) begin
    if (sd_rst) begin
      cmd_o        <= 1'b1;
      cmd_oe       <= 1'b0;
      idx_q        <= 6'd0;
      rtype_q      <= RESP_NONE;
      tx_shift     <= 40'd0;
      tx_cnt       <= 6'd0;
      rx_cnt       <= 8'd0;
      rx_shift     <= '0;
      wait_cnt     <= '0;
      ncc_cnt      <= '0;
      resp         <= 120'd0;
      resp_timeout <= 1'b0;
      resp_crc_err <= 1'b0;
      resp_idx_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_start) begin
            idx_q        <= cmd_index;
            rtype_q      <= resp_type_e'(resp_type);
            tx_shift     <= {2'b01, cmd_index, cmd_arg};
            tx_cnt       <= 6'd0;
            wait_cnt     <= '0;
            ncc_cnt      <= '0;
            resp_timeout <= 1'b0;
            resp_crc_err <= 1'b0;
            resp_idx_err <= 1'b0;
          end
        end
        ST_TX: begin
          if (tx_en) begin
            if (tx_cnt == TX_RELEASE) begin
              cmd_oe <= 1'b0;
              cmd_o  <= 1'b1;
            end else begin
              cmd_oe <= 1'b1;
              cmd_o  <= tx_bit;
              tx_cnt <= tx_cnt + 6'd1;
              if (tx_cnt < TX_CRC_START) begin
                tx_shift <= {tx_shift[38:0], 1'b0};
              end
            end
          end
        end
        ST_WAIT_RESP: begin
          if (rx_en) begin
            if (!cmd_i) begin
              rx_shift <= '0;
              rx_cnt   <= 8'd1;
            end else if (wait_cnt == TO_LAST) begin
              resp_timeout <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        ST_RX: begin
          if (rx_en) begin
            rx_shift <= rx_frame[126:0];
            rx_cnt   <= rx_cnt + 8'd1;
            if (rx_finish) begin
              resp         <= rx_long ? rx_frame[127:8] : {82'd0, rx_frame[45:8]};
              resp_crc_err <= (crc_bad && (rtype_q != RESP_R3)) || end_bad || tbit_bad;
              resp_idx_err <= (rtype_q == RESP_R1) && idx_bad;
            end
          end
        end
        ST_NCC: begin
          if (tx_en) begin
            ncc_cnt <= ncc_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdio_cmd.sv
// Self-checking bench for sdio_cmd: strobe generator, card model and frame-level reference.
// Latency: each command runs to cmd_done under a cycle budget.
// Backpressure: stalls strobes mid-TX and pokes cmd_start while busy.
module tb_sdio_cmd;

  localparam int NCC_N   = 8;
  localparam int TO_N    = 64;
  localparam int LIMIT   = 20000;

  logic         sd_clk = 1'b0;
  logic         sd_rst = 1'b1;
  logic         tx_en = 1'b0, rx_en = 1'b0;
  logic         cmd_start = 1'b0;
  logic [5:0]   cmd_index = 6'd0;
  logic [31:0]  cmd_arg = 32'd0;
  logic [1:0]   resp_type = 2'd0;
  logic         cmd_i = 1'b1;
  logic         cmd_o, cmd_oe, cmd_busy, cmd_done;
  logic [119:0] resp;
  logic         resp_timeout, resp_crc_err, resp_idx_err;

  int vectors = 0;
  int miscompares = 0;

  // Strobe generator / card / monitor shared state
  int  div = 4;
  int  ph = 0;
  bit  stall = 1'b0;
  bit  released = 1'b0;
  int  rx_since_rel = 0;
  int  card_delay = 0;
  bit  card_q[$];
  bit  tx_bits[$];
  int  ncc_end = 0;
  bit  ncc_arm = 1'b0;
  int  ncc_seen = 0;
  int  glitch = 0;
  logic last_o = 1'b1, last_oe = 1'b0;

  logic [119:0] model_resp = 120'd0;
  logic [47:0]  last_tx_frame;

  sdio_cmd #(.RESP_TIMEOUT(TO_N), .NCC(NCC_N)) dut (
    .sd_clk       (sd_clk),
    .sd_rst       (sd_rst),
    .tx_en        (tx_en),
    .rx_en        (rx_en),
    .cmd_start    (cmd_start),
    .cmd_index    (cmd_index),
    .cmd_arg      (cmd_arg),
    .resp_type    (resp_type),
    .cmd_i        (cmd_i),
    .cmd_o        (cmd_o),
    .cmd_oe       (cmd_oe),
    .cmd_busy     (cmd_busy),
    .cmd_done     (cmd_done),
    .resp         (resp),
    .resp_timeout (resp_timeout),
    .resp_crc_err (resp_crc_err),
    .resp_idx_err (resp_idx_err)
  );

  always #5 sd_clk = ~sd_clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (long division)
  function automatic logic [6:0] crc7(input logic [127:0] msg, input int n);
    logic [134:0] r;
    r = 135'(msg) << 7;
    for (int i = n + 6; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [135:0] short_frame(input logic [5:0] ix, input logic [31:0] pl, input bit with_crc);
    logic [39:0] body;
    logic [6:0]  c;
    body = {2'b00, ix, pl};
    c = with_crc ? crc7(128'(body), 40) : 7'h7F;
    return 136'({body, c, 1'b1});
  endfunction

  function automatic logic [135:0] long_frame(input logic [119:0] cid);
    return {8'h3F, cid, crc7(128'(cid), 120), 1'b1};
  endfunction

  // Strobes, card response and line monitor, evaluated away from the active edge
  initial begin
    forever begin
      @(negedge sd_clk);
      if (tx_en && ncc_arm) ncc_seen++;
      if (cmd_done) ncc_arm = 1'b0;
      if (tx_en && cmd_oe) tx_bits.push_back(cmd_o);
      if (tx_en && !cmd_oe && last_oe) begin
        released = 1'b1;
        rx_since_rel = 0;
        if (ncc_end == 0) ncc_arm = 1'b1;
      end
      if (!tx_en && ((cmd_o !== last_o) || (cmd_oe !== last_oe))) glitch++;
      last_o  = cmd_o;
      last_oe = cmd_oe;
      tx_en = 1'b0;
      rx_en = 1'b0;
      if (!stall) begin
        ph++;
        if (ph >= div) ph = 0;
        if (ph == 0) tx_en = 1'b1;
        else if (ph == div / 2) rx_en = 1'b1;
      end
      if (rx_en && released) begin
        rx_since_rel++;
        if (rx_since_rel > card_delay && card_q.size() > 0) cmd_i = card_q.pop_front();
        else cmd_i = 1'b1;
        if (ncc_end != 0 && rx_since_rel == ncc_end) ncc_arm = 1'b1;
      end
    end
  end

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input logic [135:0] frame, input int nbits, input int delay,
                         input int stall_at, input bit poke, input bit do_rst);
    logic [47:0]  exp_tx;
    logic [119:0] exp_resp;
    logic [47:0]  got_tx;
    bit exp_to, exp_crc, exp_idx;
    int cyc;
    logic snap_o, snap_oe;
    int snap_n;

    // Reference expectations from the frame rules
    exp_tx   = {2'b01, idx, arg, crc7(128'({2'b01, idx, arg}), 40), 1'b1};
    exp_to   = (rt != 2'b00) && (nbits == 0 || delay >= TO_N);
    exp_crc  = 1'b0;
    exp_idx  = 1'b0;
    exp_resp = model_resp;
    if (rt != 2'b00 && !exp_to) begin
      if (nbits == 48) begin
        exp_resp = 120'(frame[45:8]);
        exp_crc  = ((rt != 2'b11) && (crc7(128'(frame[47:8]), 40) != frame[7:1])) || !frame[0] || frame[46];
        exp_idx  = (rt == 2'b01) && (frame[45:40] != idx);
      end else begin
        exp_resp = frame[127:8];
        exp_crc  = (crc7(128'(frame[127:8]), 120) != frame[7:1]) || !frame[0];
      end
    end

    card_q.delete();
    if (!exp_to) for (int i = nbits - 1; i >= 0; i--) card_q.push_back(frame[i]);
    card_delay = delay;
    ncc_end  = (rt == 2'b00) ? 0 : (exp_to ? TO_N : delay + nbits);
    tx_bits.delete();
    ncc_seen = 0;
    ncc_arm  = 1'b0;
    released = 1'b0;
    glitch   = 0;

    cmd_index = idx; cmd_arg = arg; resp_type = rt;
    @(negedge sd_clk);
    cmd_start = 1'b1;
    @(negedge sd_clk);
    cmd_start = 1'b0;
    cmd_index = 6'($urandom); cmd_arg = $urandom; resp_type = 2'($urandom);
    chk("busy_set", cmd_busy, 1'b1);

    if (poke) begin
      repeat (10) @(negedge sd_clk);
      cmd_index = ~idx; cmd_arg = ~arg;
      cmd_start = 1'b1;
      @(negedge sd_clk);
      cmd_start = 1'b0;
    end

    if (stall_at > 0) begin
      cyc = 0;
      while (tx_bits.size() < stall_at && cyc < LIMIT) begin @(negedge sd_clk); cyc++; end
      stall = 1'b1;
      repeat (3) @(negedge sd_clk);
      snap_o = cmd_o; snap_oe = cmd_oe; snap_n = tx_bits.size();
      repeat (60) @(negedge sd_clk);
      chk("stall_cmd_o", cmd_o, snap_o);
      chk("stall_cmd_oe", cmd_oe, 1'b1);
      chk("stall_bits", 32'(tx_bits.size()), 32'(snap_n));
      chk("stall_busy", cmd_busy, 1'b1);
      stall = 1'b0;
    end

    if (do_rst) begin
      cyc = 0;
      while (!(released && rx_since_rel >= delay + 20) && cyc < LIMIT) begin @(negedge sd_clk); cyc++; end
      chk("rst_reached_rx", cyc < LIMIT, 1'b1);
      sd_rst = 1'b1;
      @(negedge sd_clk);
      chk("abort_oe", cmd_oe, 1'b0);
      chk("abort_busy", cmd_busy, 1'b0);
      chk("abort_done", cmd_done, 1'b0);
      chk("abort_resp", resp, 120'd0);
      sd_rst = 1'b0;
      released = 1'b0;
      card_q.delete();
      model_resp = 120'd0;
      cyc = 0;
      repeat (300) begin @(negedge sd_clk); if (cmd_done) cyc++; end
      chk("abort_no_done", 32'(cyc), 32'd0);
      return;
    end

    cyc = 0;
    while (!cmd_done && cyc < LIMIT) begin @(negedge sd_clk); cyc++; end
    chk("done_seen", cmd_done, 1'b1);
    chk("busy_at_done", cmd_busy, 1'b0);
    chk("resp", resp, exp_resp);
    chk("timeout", resp_timeout, exp_to);
    chk("crc_err", resp_crc_err, exp_crc);
    chk("idx_err", resp_idx_err, exp_idx);
    @(negedge sd_clk);
    chk("done_pulse", cmd_done, 1'b0);
    chk("ncc_strobes", 32'(ncc_seen), 32'(NCC_N));
    chk("tx_len", 32'(tx_bits.size()), 32'd48);
    got_tx = 48'd0;
    foreach (tx_bits[i]) got_tx = {got_tx[46:0], tx_bits[i]};
    chk("tx_frame", got_tx, exp_tx);
    chk("strobe_only", 32'(glitch), 32'd0);
    last_tx_frame = got_tx;
    model_resp = exp_resp;
  endtask

  initial begin
    logic [135:0] f;
    logic [5:0]   ix;
    logic [1:0]   rt;
    int           d;

    repeat (4) @(negedge sd_clk);
    sd_rst = 1'b0;
    @(negedge sd_clk);
    chk("rst_cmd_o", cmd_o, 1'b1);
    chk("rst_cmd_oe", cmd_oe, 1'b0);
    chk("rst_busy", cmd_busy, 1'b0);
    chk("rst_done", cmd_done, 1'b0);
    chk("rst_resp", resp, 120'd0);
    chk("rst_flags", {resp_timeout, resp_crc_err, resp_idx_err}, 3'b000);

    // CMD0, no response
    run_cmd(6'd0, 32'd0, 2'b00, 136'd0, 0, 0, 0, 1'b0, 1'b0);
    chk("cmd0_lit", last_tx_frame, 48'h40_0000_0000_95);

    // CMD8 with a good R7
    run_cmd(6'd8, 32'h1AA, 2'b01, 136'(48'h08_000001AA_13), 48, 5, 0, 1'b0, 1'b0);
    chk("cmd8_lit", last_tx_frame, 48'h48_0000_01AA_87);
    chk("cmd8_resp", resp, 120'h08_0000_01AA);
    chk("cmd8_ok", {resp_crc_err, resp_idx_err}, 2'b00);

    // Wrong index with valid CRC, then a flipped argument bit
    run_cmd(6'd8, 32'h1AA, 2'b01, short_frame(6'h09, 32'h1AA, 1'b1), 48, 5, 0, 1'b0, 1'b0);
    chk("cmd8_idx_err", resp_idx_err, 1'b1);
    run_cmd(6'd8, 32'h1AA, 2'b01, 136'(48'h08_000001AA_13) ^ (136'd1 << 8), 48, 5, 0, 1'b0, 1'b0);
    chk("cmd8_crc_err", resp_crc_err, 1'b1);

    // CMD17 with no card answer
    run_cmd(6'd17, 32'd0, 2'b01, 136'd0, 0, 0, 0, 1'b0, 1'b0);
    chk("cmd17_lit", last_tx_frame, 48'h51_0000_0000_55);
    chk("cmd17_to", resp_timeout, 1'b1);

    // CMD2 with a long R2, stalled mid-TX and poked while busy
    run_cmd(6'd2, 32'd0, 2'b10, long_frame({$urandom, $urandom, $urandom, 24'($urandom)}), 136, 3, 20, 1'b1, 1'b0);

    // Reset in the middle of a long response
    run_cmd(6'd2, 32'd0, 2'b10, long_frame({$urandom, $urandom, $urandom, 24'($urandom)}), 136, 3, 0, 1'b0, 1'b1);

    // Randomised commands
    for (int n = 0; n < 24; n++) begin
      div = $urandom_range(2, 4);
      ix  = 6'($urandom);
      rt  = 2'($urandom);
      d   = ($urandom_range(0, 7) == 0) ? $urandom_range(64, 68) : $urandom_range(0, 12);
      f   = 136'd0;
      case (rt)
        2'b01: begin
          f = short_frame(($urandom_range(0, 3) == 0) ? 6'($urandom) : ix, $urandom, 1'b1);
          if ($urandom_range(0, 3) == 0) f = f ^ (136'd1 << $urandom_range(0, 46));
        end
        2'b11: begin
          f = short_frame(6'h3F, $urandom, 1'b0);
          if ($urandom_range(0, 3) == 0) f = f ^ (136'd1 << $urandom_range(0, 46));
        end
        2'b10: begin
          f = long_frame({$urandom, $urandom, $urandom, 24'($urandom)});
          if ($urandom_range(0, 3) == 0) f = f ^ (136'd1 << $urandom_range(0, 134));
        end
        default: f = 136'd0;
      endcase
      run_cmd(ix, $urandom, rt, f, (rt == 2'b00) ? 0 : ((rt == 2'b10) ? 136 : 48), d,
              0, ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdio_cmd.md
Name: sdio_cmd

Overview:
- Command-line engine of the SD host. Consumes the `tx_en`/`rx_en` strobes of the SD clock generator, which sits directly upstream.
- Serialises a 48-bit command (start, transmission bit, index, argument, CRC7, end) onto the CMD line.
- Then receives and checks the card response (none, 48-bit or 136-bit) and enforces the Ncc gap before returning idle.
- Sits between the register/control block and the pad.

Parameters:
- RESP_TIMEOUT, 64: rx_en strobes waited for a response start bit (Ncr) before timeout.
- NCC, 8: tx_en strobes the line stays released after the command/response completes.

Ports:
- sd_clk  input  1  system clock; also clocks the SD clock generator.
- sd_rst  input  1  reset, synchronous, active-high.
- tx_en  input  1  one-cycle strobe; CMD output may change only in this cycle.
- rx_en  input  1  one-cycle strobe; CMD input is sampled only in this cycle.
- cmd_start  input  1  pulse; launches a command when idle.
- cmd_index  input  6  command index.
- cmd_arg  input  32  command argument.
- resp_type  input  2  00 none, 01 short R1/R6/R7, 10 long R2, 11 short without CRC/index check (R3).
- cmd_i  input  1  CMD pad input.
- cmd_o  output  1  CMD pad output.
- cmd_oe  output  1  CMD pad output enable.
- cmd_busy  output  1  high from accepted start until done.
- cmd_done  output  1  one-cycle completion pulse.
- resp  output  120  response payload.
- resp_timeout  output  1  status for last command.
- resp_crc_err  output  1  status for last command.
- resp_idx_err  output  1  status for last command.

Behaviour:
- Reset values:
  - Outputs: cmd_o=1, cmd_oe=0, cmd_busy=0, cmd_done=0, resp=0, all error flags 0.
  - FSM: IDLE.
  - Reset mid-operation aborts with no cmd_done.
- Operand capture: cmd_start in IDLE latches cmd_index, cmd_arg and resp_type, clears the three error flags and sets cmd_busy next cycle. cmd_start is ignored while busy.
- FSM states: IDLE -> TX -> (WAIT_RESP -> RX) -> NCC -> DONE -> IDLE.
- TX state:
  - At each tx_en: drive cmd_oe=1 and the next bit, MSB first: 0, 1, index[5:0], arg[31:0], CRC7[6:0], 1.
  - A 6-bit counter covers 48 bits.
  - CRC7 polynomial is x^7+x^3+1, init 0, computed over the first 40 bits.
- Line release: the tx_en after the end bit sets cmd_oe=0, cmd_o=1.
  - resp_type 00: go to NCC.
  - Otherwise: go to WAIT_RESP.
- WAIT_RESP state:
  - Count rx_en strobes.
  - cmd_i==0 at an rx_en is the start bit: go to RX, bit count = 1.
  - Counter reaches RESP_TIMEOUT with no start bit: set resp_timeout and go to NCC.
- RX state:
  - Shift cmd_i at each rx_en until 48 bits (short) or 136 bits (long) have been taken, start bit included; 8-bit counter.
  - Short responses: resp[37:0] = received bits 45..8, upper bits 0. CRC covers bits 47..8.
  - Long responses: resp[119:0] = bits 127..8. CRC covers bits 127..8 only; the first 8 bits are excluded.
  - resp is updated only at completion.
- Response checks:
  - resp_crc_err = (received CRC != computed CRC) OR (end bit != 1). The CRC part is skipped for resp_type 11.
  - resp_idx_err = (received bits 45..40 != latched index), for resp_type 01 only.
  - Transmission bit (bit 46) != 0 sets resp_crc_err.
- NCC state: wait NCC tx_en strobes with cmd_oe=0.
- DONE state: one cycle with cmd_done=1; cmd_busy drops in the same cycle.
- Strobe collision: tx_en and rx_en in the same cycle cannot occur by construction. If it does, rx_en takes priority in RX/WAIT_RESP and tx_en in TX/NCC.
- Stalled clock: no strobes (clock paused or disabled) means the FSM holds its state indefinitely; the timeout counts strobes, not sd_clk cycles.

Decomposition:
- Shared package sdio_pkg holds:
  - resp_type encodings.
  - CRC7 polynomial constant 7'h09.
  - Frame lengths 48/136.
  - FSM state encoding.
- Sub-module sdio_crc7: serial CRC7 with clear, enable and data-bit inputs and a 7-bit output. It is instantiated once here and reused later by the data path.

Test Plan:
- CMD0, arg 0, resp 00 -> CMD bitstream 0x40_00000000_95, then cmd_oe=0 for 8 tx_en, then cmd_done with no errors.
- CMD8, arg 0x1AA, resp 01; card returns 0x08_000001AA_13 after 5 strobes -> TX 0x48_000001AA_87; resp=0x08000001AA; crc_err=0, idx_err=0.
- Same as above with card returning index 0x09 and a correct CRC -> resp_idx_err=1; with one flipped arg bit -> resp_crc_err=1.
- CMD17, resp 01, cmd_i held 1 -> TX 0x51_00000000_55; resp_timeout=1 after 64 rx_en; cmd_done asserted; resp unchanged.
- CMD2, resp 10, 136-bit R2 with known CID -> resp[119:0]=CID[127:8]; crc_err=0.
- Stall and abort: with strobes stopped mid-TX, the FSM and cmd_o hold. Assert sd_rst mid-RX -> next cycle IDLE, cmd_oe=0, no cmd_done. A new cmd_start while busy is ignored.
